// File: rtl/jt6295_chan_seq.sv
// Four-channel ADPCM phrase sequencer: slot timing, per-channel playback state,
// and a single ROM fetch engine refilling one-byte channel buffers.
module jt6295_chan_seq (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen4,
   input  logic        cen1,
   input  logic [17:0] start_addr,
   input  logic [17:0] stop_addr,
   input  logic [3:0]  att,
   input  logic [3:0]  start,
   input  logic [3:0]  stop,
   output logic [3:0]  busy,
   output logic [3:0]  ack,
   output logic [17:0] rom_addr,
   output logic        rom_cs,
   input  logic [7:0]  rom_data,
   input  logic        rom_ok,
   output logic [3:0]  nib,
   output logic [3:0]  nib_att,
   output logic [1:0]  nib_ch,
   output logic        nib_valid,
   output logic        nib_first,
   output logic        zero
);

   localparam int unsigned NCH = 4;
   localparam int unsigned AW  = 18;
   localparam int unsigned NW  = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} fetch_t;

   fetch_t          state, state_nxt;
   logic [1:0]      slot;
   logic [NW-1:0]   cur    [NCH];
   logic [AW-1:0]   end_q  [NCH];
   logic [3:0]      att_q  [NCH];
   logic [7:0]      buf_q  [NCH];
   logic [NCH-1:0]  buf_ok;
   logic [NCH-1:0]  first;
   logic [1:0]      fch;
   logic            fch_kill;
   logic            sel_hit;
   logic [1:0]      sel_ch;
   logic            fetch_go;
   logic            buf_wr;

   // Lowest-index playing channel whose buffer needs a refill
   always_comb begin
      sel_hit = 1'b0;
      sel_ch  = 2'd0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (!sel_hit && busy[i] && !buf_ok[i] && !stop[i]) begin
            sel_hit = 1'b1;
            sel_ch  = 2'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sel_hit) state_nxt = S_REQ;
         S_REQ:   state_nxt = S_WAIT;
         S_WAIT:  if (rom_ok) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A read whose channel was stopped meanwhile still completes, but its byte is dropped
   always_comb begin
      fetch_go = 1'b0;
      buf_wr   = 1'b0;
      case (state)
         S_IDLE:  fetch_go = sel_hit;
         S_WAIT:  buf_wr   = rom_ok && !fch_kill;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot      <= 2'd0;
         busy      <= '0;
         ack       <= '0;
         buf_ok    <= '0;
         first     <= '0;
         rom_addr  <= '0;
         rom_cs    <= 1'b0;
         fch       <= 2'd0;
         fch_kill  <= 1'b0;
         nib       <= 4'd0;
         nib_att   <= 4'd0;
         nib_ch    <= 2'd0;
         nib_valid <= 1'b0;
         nib_first <= 1'b0;
         zero      <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++) begin
            cur[i]   <= '0;
            end_q[i] <= '0;
            att_q[i] <= '0;
            buf_q[i] <= '0;
         end
      end else begin
         nib_valid <= 1'b0;
         nib_first <= 1'b0;
         zero      <= 1'b0;
         rom_cs    <= (state_nxt != S_IDLE);
         if (fetch_go) begin
            rom_addr <= cur[sel_ch][AW:1];
            fch      <= sel_ch;
            fch_kill <= 1'b0;
         end
         if (buf_wr) begin
            buf_q[fch]  <= rom_data;
            buf_ok[fch] <= 1'b1;
         end
         if (state != S_IDLE && cen4 && stop[fch]) fch_kill <= 1'b1;
         if (cen4) begin
            slot <= slot + 2'd1;
            zero <= (slot == 2'd3);
            // Emit the next nibble; an empty buffer is a silent underrun
            if (busy[slot] && buf_ok[slot] && !stop[slot]) begin
               nib       <= cur[slot][0] ? buf_q[slot][3:0] : buf_q[slot][7:4];
               nib_att   <= att_q[slot];
               nib_ch    <= slot;
               nib_valid <= 1'b1;
               nib_first <= first[slot];
               first[slot] <= 1'b0;
               cur[slot]   <= cur[slot] + NW'(1);
               if (cur[slot][0]) begin
                  buf_ok[slot] <= 1'b0;
                  if (cur[slot][AW:1] == end_q[slot]) busy[slot] <= 1'b0;
               end
            end
            // Starts on a busy channel are acknowledged but ignored
            if (start[slot] && !stop[slot]) begin
               ack[slot] <= 1'b1;
               if (!busy[slot]) begin
                  cur[slot]    <= {start_addr, 1'b0};
                  end_q[slot]  <= stop_addr;
                  att_q[slot]  <= att;
                  busy[slot]   <= 1'b1;
                  first[slot]  <= 1'b1;
                  buf_ok[slot] <= 1'b0;
               end
            end
         end
         for (int unsigned i = 0; i < NCH; i++) begin
            if (!start[i]) ack[i] <= 1'b0;
            if (cen4 && stop[i]) begin
               busy[i]   <= 1'b0;
               buf_ok[i] <= 1'b0;
            end
         end
      end
   end

   // cen1 carries no state; it must only ever land on a slot strobe
   cen1_align: assert property (@(posedge clk) disable iff (rst) cen1 |-> cen4);

endmodule

// File: tb/tb_jt6295_chan_seq.sv
// Randomized scoreboard bench for jt6295_chan_seq: expected nibble streams are
// built per phrase from ROM contents and matched as the DUT emits them.
module tb_jt6295_chan_seq;

   logic        rst, clk, cen4, cen1;
   logic [17:0] start_addr, stop_addr;
   logic [3:0]  att, start, stop;
   logic [3:0]  busy, ack;
   logic [17:0] rom_addr;
   logic        rom_cs;
   logic [7:0]  rom_data;
   logic        rom_ok;
   logic [3:0]  nib, nib_att;
   logic [1:0]  nib_ch;
   logic        nib_valid, nib_first, zero;

   jt6295_chan_seq dut (
      .rst(rst), .clk(clk), .cen4(cen4), .cen1(cen1),
      .start_addr(start_addr), .stop_addr(stop_addr), .att(att),
      .start(start), .stop(stop), .busy(busy), .ack(ack),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
      .nib(nib), .nib_att(nib_att), .nib_ch(nib_ch), .nib_valid(nib_valid),
      .nib_first(nib_first), .zero(zero)
   );

   typedef struct {
      logic [1:0] ch;
      logic [3:0] n;
      logic [3:0] at;
      logic       first;
      logic       last;
   } exp_t;

   exp_t        sb[$];
   logic [17:0] rd_log[$];
   int          checks, errors, rom_delay, ncen, phase;
   logic        zero_exp;
   logic [1:0]  exp_ch;
   logic        prev_cs;
   logic [17:0] prev_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cen4 = 1'b0; cen1 = 1'b0; phase = 0;
      forever begin
         @(posedge clk); #1;
         cen4 = (phase % 4 == 3);
         cen1 = (phase % 16 == 15);
         phase++;
      end
   end

   // Round position as seen from outside: count served slots since reset
   always @(posedge clk) begin
      if (rst) ncen = 0;
      else if (cen4) ncen++;
      zero_exp = !rst && cen4 && (ncen % 4 == 0);
      exp_ch   = 2'((ncen + 3) % 4);
   end

   function automatic logic [7:0] rom_byte(input logic [17:0] a);
      if (a == 18'h00100) return 8'hA5;
      if (a == 18'h00101) return 8'h3C;
      return 8'((a * 18'd29) ^ (a >> 7) ^ 18'h6B);
   endfunction

   function automatic int pending(input int ch);
      int c = 0;
      foreach (sb[i]) if (sb[i].ch == 2'(ch)) c++;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_phrase(input int ch, input logic [17:0] sa, input logic [17:0] ea,
                              input logic [3:0] at);
      logic [17:0] a = sa;
      logic [7:0]  b;
      logic        f = 1'b1;
      for (int k = 0; k < 64; k++) begin
         b = rom_byte(a);
         sb.push_back('{ch: 2'(ch), n: b[7:4], at: at, first: f, last: 1'b0});
         f = 1'b0;
         sb.push_back('{ch: 2'(ch), n: b[3:0], at: at, first: 1'b0, last: (a == ea)});
         if (a == ea) break;
         a = a + 18'd1;
      end
   endtask

   task automatic flush_ch(input int ch);
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].ch == 2'(ch)) sb.delete(i);
   endtask

   // ROM model: answers each read after rom_delay clocks
   initial begin
      logic [17:0] a;
      rom_ok = 1'b0; rom_data = 8'd0;
      forever begin
         @(negedge clk);
         if (rom_cs) begin
            a = rom_addr;
            rd_log.push_back(a);
            repeat (rom_delay) @(posedge clk);
            #1 rom_ok = 1'b1; rom_data = rom_byte(a);
            @(posedge clk);
            #1 rom_ok = 1'b0;
            while (rom_cs) @(negedge clk);
         end
      end
   end

   // Monitor: pop and compare every emitted nibble
   always @(negedge clk) begin
      int idx;
      if (rst) prev_cs = 1'b0;
      else begin
         chk("zero", 32'(zero), 32'(zero_exp));
         if (rom_cs && prev_cs) chk("rom_addr_stable", 32'(rom_addr), 32'(prev_addr));
         prev_cs = rom_cs; prev_addr = rom_addr;
         if (nib_valid) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].ch == nib_ch) idx = i;
            checks++;
            if (idx < 0) begin
               errors++;
               $display("FAIL unexpected_nib: got ch%0d nib %0h expected none at %0t", nib_ch, nib, $time);
            end else begin
               chk("nib", 32'(nib), 32'(sb[idx].n));
               chk("nib_att", 32'(nib_att), 32'(sb[idx].at));
               chk("nib_first", 32'(nib_first), 32'(sb[idx].first));
               chk("busy_track", 32'(busy[nib_ch]), 32'(!sb[idx].last));
               sb.delete(idx);
            end
            chk("nib_ch_slot", 32'(nib_ch), 32'(exp_ch));
         end
      end
   end

   task automatic start_ch(input int ch, input logic [17:0] sa, input logic [17:0] ea,
                           input logic [3:0] at);
      logic got = 1'b0, was_busy = 1'b0;
      @(posedge clk); #1;
      start_addr = sa; stop_addr = ea; att = at; start[ch] = 1'b1;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk);
         was_busy = (pending(ch) != 0);
         @(negedge clk);
         if (ack[ch]) begin got = 1'b1; break; end
      end
      chk("ack_rise", 32'(got), 32'd1);
      if (got && !was_busy) push_phrase(ch, sa, ea, at);
      start[ch] = 1'b0;
      @(negedge clk);
      chk("ack_fall", 32'(ack[ch]), 32'd0);
   endtask

   task automatic stop_ch(input int ch);
      @(posedge clk); #1 stop[ch] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         if (cen4) break;
      end
      #1 stop[ch] = 1'b0;
      flush_ch(ch);
      @(negedge clk);
      chk("busy_after_stop", 32'(busy[ch]), 32'd0);
   endtask

   task automatic drain(input int budget);
      for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_pending(input int ch, input int lim, input logic need_cs);
      logic ok = 1'b0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         if (pending(ch) <= lim && (rom_cs || !need_cs)) begin ok = 1'b1; break; end
      end
      chk("wait_progress", 32'(ok), 32'd1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_rom_cs", 32'(rom_cs), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_nib_valid", 32'(nib_valid), 32'd0);
      chk("rst_nib_first", 32'(nib_first), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_nib", 32'({nib, nib_att, nib_ch}), 32'd0);
   endtask

   initial begin
      logic        saw_a, saw_b;
      logic [17:0] sa;
      int          ch;
      checks = 0; errors = 0; rom_delay = 2;
      rst = 1'b1; start = '0; stop = '0; start_addr = '0; stop_addr = '0; att = '0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1 rst = 1'b0;

      // Basic phrase on ch0: A,5,3,C
      rd_log.delete();
      start_ch(0, 18'h00100, 18'h00101, 4'h3);
      drain(2000);
      chk("s1_reads", 32'(rd_log.size()), 32'd2);
      if (rd_log.size() == 2) begin
         chk("s1_rd0", 32'(rd_log[0]), 32'h100);
         chk("s1_rd1", 32'(rd_log[1]), 32'h101);
      end

      // Address wrap through 0x3FFFF -> 0
      rd_log.delete();
      start_ch(2, 18'h3FFFF, 18'h00000, 4'h5);
      drain(2000);
      chk("s2_reads", 32'(rd_log.size()), 32'd2);
      if (rd_log.size() == 2) begin
         chk("s2_rd0", 32'(rd_log[0]), 32'h3FFFF);
         chk("s2_rd1", 32'(rd_log[1]), 32'h00000);
      end

      // Stop mid-phrase with a slow read in flight, then restart the channel
      rom_delay = 40;
      start_ch(1, 18'h02000, 18'h02007, 4'h7);
      wait_pending(1, 14, 1'b1);
      stop_ch(1);
      start_ch(1, 18'h03000, 18'h03001, 4'h2);
      drain(8000);

      // Start and stop together: stop wins
      rom_delay = 2;
      @(posedge clk); #1 start[3] = 1'b1; stop[3] = 1'b1;
      saw_a = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ack[3] || busy[3]) saw_a = 1'b1;
      end
      chk("s4_stop_wins", 32'(saw_a), 32'd0);
      start[3] = 1'b0; stop[3] = 1'b0;

      // Start on a busy channel is acknowledged but does not reload
      rd_log.delete();
      start_ch(3, 18'h00500, 18'h00503, 4'h1);
      wait_pending(3, 6, 1'b0);
      start_ch(3, 18'h00900, 18'h009FF, 4'h4);
      drain(3000);
      chk("s4_reads", 32'(rd_log.size()), 32'd4);
      foreach (rd_log[i]) chk("s4_rd_seq", 32'(rd_log[i]), 32'(18'h00500 + 18'(i)));

      // Slow ROM: underruns, still complete and ordered
      rom_delay = 40;
      start_ch(0, 18'h01234, 18'h01236, 4'h9);
      drain(6000);

      // Randomized mix of starts and stops across channels
      rom_delay = int'($urandom_range(2, 6));
      for (int it = 0; it < 30; it++) begin
         ch = int'($urandom_range(0, 3));
         if (pending(ch) == 0) begin
            sa = 18'($urandom);
            start_ch(ch, sa, 18'(sa + 18'($urandom_range(0, 3))), 4'($urandom));
         end else if ($urandom_range(0, 3) == 0) begin
            stop_ch(ch);
         end
         repeat ($urandom_range(0, 30)) @(posedge clk);
      end
      drain(20000);

      // Reset in the middle of a ROM wait; late rom_ok must be ignored
      rom_delay = 10;
      start_ch(2, 18'h00040, 18'h00041, 4'h6);
      saw_a = 1'b0;
      for (int k = 0; k < 400 && !saw_a; k++) begin
         @(negedge clk);
         saw_a = rom_cs;
      end
      chk("s6_rom_cs_seen", 32'(saw_a), 32'd1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs();
      sb.delete();
      @(posedge clk); #1 rst = 1'b0;
      saw_a = 1'b0; saw_b = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (rom_cs) saw_a = 1'b1;
         if (nib_valid || busy != 4'd0) saw_b = 1'b1;
      end
      chk("s6_no_fetch", 32'(saw_a), 32'd0);
      chk("s6_no_play", 32'(saw_b), 32'd0);
      rom_delay = 2;
      start_ch(2, 18'h00040, 18'h00041, 4'h6);
      drain(2000);

      repeat (20) @(negedge clk);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_sb", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
